fibonacci: RTL and testbench

//   Iterative 8-bit Fibonacci datapath with an embedded 3-state controller.

---
 rtl/fibonacci.sv | 112 +++++++++++
 tb/tb_fibonacci.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fibonacci.sv
`default_nettype none
// ============================================================================
//  Module   : fibonacci
//  Purpose  : Iterative 8-bit Fibonacci datapath with a LOAD/RUN/DONE
//             controller. Seeds two term registers, then advances the pair
//             once per clock until the iteration counter reaches the limit.
//  Revision : 1.0 - initial release
// ============================================================================
module fibonacci (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] n1,
  input  logic [7:0] n2,
  input  logic [7:0] N,
  input  logic [7:0] n3,
  input  logic       enable_reg1,
  input  logic       enable_reg2,
  input  logic       enable_regN,
  input  logic       enable_count,
  output logic [7:0] saida_do_comparador,
  output logic [7:0] FIB_SAIDA
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_reg1;
  logic [7:0] r_reg2;
  logic [7:0] r_reg_n;
  logic [7:0] r_count;

  logic [7:0] w_reg1_next;
  logic [7:0] w_reg2_next;
  logic [7:0] w_reg_n_next;
  logic [7:0] w_count_next;

  logic       w_ge;
  logic [7:0] w_sum;

  // Limit compare is unsigned; the sum wraps modulo 256 with no flag.
  assign w_ge  = (r_count >= r_reg_n);
  assign w_sum = r_reg1 + r_reg2;

  // State register: reset returns to LOAD so the next edge reseeds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: all cleared by reset, otherwise take the computed next values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg1  <= 8'd0;
      r_reg2  <= 8'd0;
      r_reg_n <= 8'd0;
      r_count <= 8'd0;
    end else begin
      r_reg1  <= w_reg1_next;
      r_reg2  <= w_reg2_next;
      r_reg_n <= w_reg_n_next;
      r_count <= w_count_next;
    end
  end

  // Next-state and next-register logic; everything holds unless a state says otherwise.
  always_comb begin
    w_state_next = r_state;
    w_reg1_next  = r_reg1;
    w_reg2_next  = r_reg2;
    w_reg_n_next = r_reg_n;
    w_count_next = r_count;
    case (r_state)
      S_LOAD: begin
        if (enable_reg1)  w_reg1_next  = n1;
        if (enable_reg2)  w_reg2_next  = n2;
        if (enable_regN)  w_reg_n_next = N;
        if (enable_count) w_count_next = n3;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        // Limit met: freeze everything. The counter therefore never wraps here.
        if (w_ge) begin
          w_state_next = S_DONE;
        end else begin
          if (enable_reg1)  w_reg1_next  = r_reg2;
          if (enable_reg2)  w_reg2_next  = w_sum;
          if (enable_count) w_count_next = r_count + 8'd1;
        end
      end
      S_DONE: begin
        // Terminal: only reset leaves this state.
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  assign FIB_SAIDA           = r_reg2;
  assign saida_do_comparador = {7'b0, w_ge};

endmodule
`default_nettype wire

// File: tb/tb_fibonacci.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fibonacci
//  Purpose  : Directed self-checking bench for the fibonacci datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fibonacci;

  logic       clock;
  logic       reset;
  logic [7:0] n1;
  logic [7:0] n2;
  logic [7:0] N;
  logic [7:0] n3;
  logic       enable_reg1;
  logic       enable_reg2;
  logic       enable_regN;
  logic       enable_count;
  logic [7:0] saida_do_comparador;
  logic [7:0] FIB_SAIDA;

  int n_cmp;
  int n_bad;

  fibonacci dut (
    .clock               (clock),
    .reset               (reset),
    .n1                  (n1),
    .n2                  (n2),
    .N                   (N),
    .n3                  (n3),
    .enable_reg1         (enable_reg1),
    .enable_reg2         (enable_reg2),
    .enable_regN         (enable_regN),
    .enable_count        (enable_count),
    .saida_do_comparador (saida_do_comparador),
    .FIB_SAIDA           (FIB_SAIDA)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_both(input string tag, input logic [7:0] fib_exp, input logic [7:0] cmp_exp);
    chk({tag, "_fib"}, FIB_SAIDA, fib_exp);
    chk({tag, "_cmp"}, saida_do_comparador, cmp_exp);
  endtask

  // Advance n rising edges; returns on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic setup(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] lim, input logic [7:0] c0);
    n1 = a; n2 = b; N = lim; n3 = c0;
    enable_reg1 = 1'b1; enable_reg2 = 1'b1;
    enable_regN = 1'b1; enable_count = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    setup(8'd0, 8'd1, 8'd10, 8'd0);

    // 1: reset asserted, before any clock edge
    #1;
    chk_both("reset_async", 8'd0, 8'h01);

    // 2: 0,1 seeds, N=10 -> 89 after 12 edges
    @(negedge clock);
    reset = 1'b0;
    tick(1);
    chk_both("c2_load", 8'd1, 8'h00);
    tick(5);
    chk_both("c2_step5", 8'd8, 8'h00);
    tick(5);
    chk_both("c2_step10", 8'd89, 8'h01);
    tick(1);
    chk_both("c2_done", 8'd89, 8'h01);
    tick(3);
    chk_both("c2_hold", 8'd89, 8'h01);

    // 3: n3 >= N -> no step, output stays at n2 seed
    reset = 1'b1;
    #1;
    chk_both("c3_reset", 8'd0, 8'h01);
    setup(8'd1, 8'd2, 8'd4, 8'd8);
    @(negedge clock);
    reset = 1'b0;
    tick(1);
    chk_both("c3_load", 8'd2, 8'h01);
    tick(3);
    chk_both("c3_hold", 8'd2, 8'h01);

    // 4: N=13 -> F(14)=377 wraps to 121
    reset = 1'b1;
    setup(8'd0, 8'd1, 8'd13, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(8);
    chk_both("c4_step7", 8'd21, 8'h00);
    tick(7);
    chk_both("c4_done", 8'd121, 8'h01);

    // 5: enable_reg1 low during RUN -> reg1 stays 0, output stays 1
    reset = 1'b1;
    setup(8'd0, 8'd1, 8'd10, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(1);
    enable_reg1 = 1'b0;
    tick(4);
    chk_both("c5_mid", 8'd1, 8'h00);
    tick(8);
    chk_both("c5_done", 8'd1, 8'h01);

    // 6: reset mid-RUN aborts immediately, then recomputes
    reset = 1'b1;
    setup(8'd0, 8'd1, 8'd10, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(6);
    chk_both("c6_step5", 8'd8, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk_both("c6_abort", 8'd0, 8'h01);
    @(negedge clock);
    reset = 1'b0;
    tick(12);
    chk_both("c6_redo", 8'd89, 8'h01);

    // 7: enable_regN low -> limit stays 0, so no step occurs
    reset = 1'b1;
    setup(8'd3, 8'd5, 8'd10, 8'd0);
    enable_regN = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick(1);
    chk_both("c7_load", 8'd5, 8'h01);
    tick(3);
    chk_both("c7_hold", 8'd5, 8'h01);

    // 8: enable_count low -> runs on; F(21)=10946 mod 256 = 194
    reset = 1'b1;
    setup(8'd0, 8'd1, 8'd3, 8'd0);
    enable_count = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick(21);
    chk_both("c8_free_run", 8'd194, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
